tiny_cache_ctrl: RTL



---
 rtl/tiny_cache_pkg.sv | 25 ++
 rtl/tiny_cache_line_store.sv | 56 +++++
 rtl/tiny_cache_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_cache_pkg.sv
// Shared codes for the tiny cache controller: response codes,
// request codes and FSM state encoding.
package tiny_cache_pkg;

   localparam logic [2:0] CACHEHIT   = 3'd4;
   localparam logic [2:0] CACHEMISS  = 3'd5;
   localparam logic [2:0] CACHEWRITE = 3'd6;
   localparam logic [2:0] CACHERESET = 3'd7;

   typedef enum logic [1:0] {
      NOTHING,
      READ,
      WRITE,
      RESET
   } req_e;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      RESP
   } state_e;

endpackage

// File: rtl/tiny_cache_line_store.sv
// Direct-mapped line storage: data/tag arrays, valid vector,
// combinational lookup, single write port and one-cycle flush.
module tiny_cache_line_store #(
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flush
);

   localparam int LINES = 1 << IDX_W;

   logic [DATA_W-1:0] data_q [LINES];
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINES-1:0]  valid_q, valid_d;

   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = '0;
      end else if (we) begin
         valid_d[wr_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data carry no reset; only valid bits are qualified.
   always_ff @(posedge clk) begin
      if (we) begin
         data_q[wr_idx] <= wr_data;
         tag_q[wr_idx]  <= wr_tag;
      end
   end

endmodule

// File: rtl/tiny_cache_ctrl.sv
// Direct-mapped write-through write-allocate cache controller.
// Optional hit/miss counters enabled by TINY_CACHE_STATS_EN.
module tiny_cache_ctrl
   import tiny_cache_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpubus_address,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              active,
   output logic              response,
   output logic [2:0]        trans,
   output logic              memory_rd,
   output logic              memory_wr,
   output logic [ADDR_W-1:0] memory_address,
   output logic [DATA_W-1:0] memory_wdata,
   input  logic [DATA_W-1:0] memory_rdata,
   input  logic              memory_ack
`ifdef TINY_CACHE_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);

   localparam int TAG_W = ADDR_W - IDX_W;

   state_e state_q, state_d;
   req_e   req_q, req_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [2:0]        trans_q, trans_d;
   logic              active_q, active_d;
   logic              resp_q, resp_d;
   logic              mrd_q, mrd_d;
   logic              mwr_q, mwr_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mwdata_q, mwdata_d;

   logic [TAG_W-1:0]  st_tag;
   logic [DATA_W-1:0] st_data;
   logic              st_valid;
   logic              st_we;
   logic              st_flush;
   logic [DATA_W-1:0] st_wdata;
   logic              hit;

   tiny_cache_line_store #(
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_store (
      .clk      (clk),
      .reset_n  (reset_n),
      .rd_idx   (addr_q[IDX_W-1:0]),
      .rd_tag   (st_tag),
      .rd_data  (st_data),
      .rd_valid (st_valid),
      .we       (st_we),
      .wr_idx   (addr_q[IDX_W-1:0]),
      .wr_tag   (addr_q[ADDR_W-1:IDX_W]),
      .wr_data  (st_wdata),
      .flush    (st_flush)
   );

   assign hit = st_valid && (st_tag == addr_q[ADDR_W-1:IDX_W]);

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      trans_d  = trans_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      st_we    = 1'b0;
      st_flush = 1'b0;
      st_wdata = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (reset || cpu_wr || cpu_rd) begin
               state_d = LOOKUP;
               addr_d  = cpubus_address;
               wdata_d = cpu_wdata;
            end
            priority case (1'b1)
               reset:   req_d = RESET;
               cpu_wr:  req_d = WRITE;
               cpu_rd:  req_d = READ;
               default: req_d = NOTHING;
            endcase
         end
         LOOKUP: begin
            unique case (req_q)
               READ: begin
                  if (hit) begin
                     rdata_d = st_data;
                     trans_d = CACHEHIT;
                     state_d = RESP;
                  end else begin
                     maddr_d = addr_q;
                     state_d = MEM_RD;
                  end
               end
               WRITE: begin
                  st_we    = 1'b1;
                  maddr_d  = addr_q;
                  mwdata_d = wdata_q;
                  state_d  = MEM_WR;
               end
               RESET: begin
                  st_flush = 1'b1;
                  rdata_d  = '0;
                  trans_d  = CACHERESET;
                  state_d  = RESP;
               end
               default: state_d = IDLE;
            endcase
         end
         MEM_RD: begin
            if (memory_ack) begin
               st_we    = 1'b1;
               st_wdata = memory_rdata;
               rdata_d  = memory_rdata;
               trans_d  = CACHEMISS;
               state_d  = RESP;
            end
         end
         MEM_WR: begin
            if (memory_ack) begin
               rdata_d = wdata_q;
               trans_d = CACHEWRITE;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Strobes follow the next state so every output is a flop.
      active_d = (state_d != IDLE);
      resp_d   = (state_d == RESP);
      mrd_d    = (state_d == MEM_RD);
      mwr_d    = (state_d == MEM_WR);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         req_q    <= NOTHING;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         trans_q  <= '0;
         active_q <= 1'b0;
         resp_q   <= 1'b0;
         mrd_q    <= 1'b0;
         mwr_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         trans_q  <= trans_d;
         active_q <= active_d;
         resp_q   <= resp_d;
         mrd_q    <= mrd_d;
         mwr_q    <= mwr_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

   assign cpu_rdata      = rdata_q;
   assign trans          = trans_q;
   assign active         = active_q;
   assign response       = resp_q;
   assign memory_rd      = mrd_q;
   assign memory_wr      = mwr_q;
   assign memory_address = maddr_q;
   assign memory_wdata   = mwdata_q;

`ifdef TINY_CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (st_flush) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end else if (state_q == RESP) begin
         if (trans_q == CACHEHIT && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
         end
         if (trans_q == CACHEMISS && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule
